// File: rtl/fsm_1010_if.sv
// Serial-bit stream and detection results between a bit source and the 1010 detector.
interface fsm_1010_if #(
  parameter int unsigned CNT_W = 8
);
  logic             in;
  logic             out;
  logic [CNT_W-1:0] match_cnt;

  modport master (output in, input out, input match_cnt);
  modport slave  (input in, output out, output match_cnt);
endinterface

// File: rtl/fsm_1010.sv
// Moore detector for the serial pattern 1010 (oldest bit first) with a
// saturating count of detections.
module fsm_1010 #(
  parameter bit          OVERLAP = 1'b1,
  parameter int unsigned CNT_W   = 8
) (
  input  logic      clk,
  input  logic      rst,
  fsm_1010_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic             out_q;
  logic [CNT_W-1:0] cnt_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S0;
    else     state <= state_nx;
  end

  // Next-state logic; unused encodings fall back to S0
  always_comb begin
    state_nx = S0;
    case (state)
      S0:      state_nx = bus.in ? S1 : S0;
      S1:      state_nx = bus.in ? S1 : S2;
      S2:      state_nx = bus.in ? S3 : S0;
      S3:      state_nx = bus.in ? S1 : S4;
      S4:      state_nx = bus.in ? (OVERLAP ? S3 : S1) : S0;
      default: state_nx = S0;
    endcase
  end

  // Flag mirrors S4 from the same edge; S4 cannot self-loop, so every S4 entry is a new match
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      out_q <= (state_nx == S4);
      if ((state_nx == S4) && (cnt_q != CNT_MAX))
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.out       = out_q;
  assign bus.match_cnt = cnt_q;

endmodule

// File: tb/tb_fsm_1010.sv
// Directed bench: three detector instances (overlap / non-overlap / 2-bit counter) share one input stream.
module tb_fsm_1010;

  logic clk;
  logic rst;
  logic din;
  int   n_cmp;
  int   n_err;

  fsm_1010_if #(.CNT_W(8)) b0 ();
  fsm_1010_if #(.CNT_W(8)) b1 ();
  fsm_1010_if #(.CNT_W(2)) b2 ();

  assign b0.in = din;
  assign b1.in = din;
  assign b2.in = din;

  fsm_1010 #(.OVERLAP(1'b1), .CNT_W(8)) u_ov (.clk(clk), .rst(rst), .bus(b0.slave));
  fsm_1010 #(.OVERLAP(1'b0), .CNT_W(8)) u_no (.clk(clk), .rst(rst), .bus(b1.slave));
  fsm_1010 #(.OVERLAP(1'b1), .CNT_W(2)) u_c2 (.clk(clk), .rst(rst), .bus(b2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one bit, clock it in, then check both 8-bit instances' flags
  task automatic step(input string tag, input logic b, input logic e_ov, input logic e_no);
    din = b;
    @(posedge clk);
    #1;
    chk({tag, "_ov_out"}, {31'd0, b0.out}, {31'd0, e_ov});
    chk({tag, "_no_out"}, {31'd0, b1.out}, {31'd0, e_no});
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    chk("rst_ov_out", {31'd0, b0.out}, 32'd0);
    chk("rst_no_out", {31'd0, b1.out}, 32'd0);
    chk("rst_ov_cnt", {24'd0, b0.match_cnt}, 32'd0);
    chk("rst_c2_cnt", {30'd0, b2.match_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    din   = 1'b0;
    #12;
    chk("init_ov_out", {31'd0, b0.out}, 32'd0);
    chk("init_no_out", {31'd0, b1.out}, 32'd0);
    chk("init_ov_cnt", {24'd0, b0.match_cnt}, 32'd0);
    chk("init_no_cnt", {24'd0, b1.match_cnt}, 32'd0);
    chk("init_c2_cnt", {30'd0, b2.match_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1,0,1,1,0,1,0: single detection after the 7th edge
    step("a1", 1'b1, 1'b0, 1'b0);
    step("a2", 1'b0, 1'b0, 1'b0);
    step("a3", 1'b1, 1'b0, 1'b0);
    step("a4", 1'b1, 1'b0, 1'b0);
    step("a5", 1'b0, 1'b0, 1'b0);
    step("a6", 1'b1, 1'b0, 1'b0);
    step("a7", 1'b0, 1'b1, 1'b1);
    chk("a_ov_cnt", {24'd0, b0.match_cnt}, 32'd1);
    chk("a_no_cnt", {24'd0, b1.match_cnt}, 32'd1);
    chk("a_c2_cnt", {30'd0, b2.match_cnt}, 32'd1);
    step("a8", 1'b0, 1'b0, 1'b0);
    step("a9", 1'b0, 1'b0, 1'b0);

    // 1,0,1,0,1,0: overlap pulses at 4 and 6, non-overlap only at 4
    step("b1", 1'b1, 1'b0, 1'b0);
    step("b2", 1'b0, 1'b0, 1'b0);
    step("b3", 1'b1, 1'b0, 1'b0);
    step("b4", 1'b0, 1'b1, 1'b1);
    step("b5", 1'b1, 1'b0, 1'b0);
    step("b6", 1'b0, 1'b1, 1'b0);
    chk("b_ov_cnt", {24'd0, b0.match_cnt}, 32'd3);
    chk("b_no_cnt", {24'd0, b1.match_cnt}, 32'd2);
    chk("b_c2_cnt", {30'd0, b2.match_cnt}, 32'd3);
    step("b7", 1'b0, 1'b0, 1'b0);

    // 1,0,1 then async reset mid-cycle, then 0: no detection
    step("d1", 1'b1, 1'b0, 1'b0);
    step("d2", 1'b0, 1'b0, 1'b0);
    step("d3", 1'b1, 1'b0, 1'b0);
    pulse_reset();
    step("d4", 1'b0, 1'b0, 1'b0);
    chk("d_ov_cnt", {24'd0, b0.match_cnt}, 32'd0);
    chk("d_no_cnt", {24'd0, b1.match_cnt}, 32'd0);

    // Reset while in S4 drops the flag without a clock edge
    step("r1", 1'b1, 1'b0, 1'b0);
    step("r2", 1'b0, 1'b0, 1'b0);
    step("r3", 1'b1, 1'b0, 1'b0);
    step("r4", 1'b0, 1'b1, 1'b1);
    pulse_reset();

    // 1,1,1,0,0,1,0,1,0: only the final 1010 matches
    step("e1", 1'b1, 1'b0, 1'b0);
    step("e2", 1'b1, 1'b0, 1'b0);
    step("e3", 1'b1, 1'b0, 1'b0);
    step("e4", 1'b0, 1'b0, 1'b0);
    step("e5", 1'b0, 1'b0, 1'b0);
    step("e6", 1'b1, 1'b0, 1'b0);
    step("e7", 1'b0, 1'b0, 1'b0);
    step("e8", 1'b1, 1'b0, 1'b0);
    step("e9", 1'b0, 1'b1, 1'b1);
    chk("e_ov_cnt", {24'd0, b0.match_cnt}, 32'd1);
    pulse_reset();

    // (10)x6 from reset: five overlapping matches saturate the 2-bit counter
    step("s1",  1'b1, 1'b0, 1'b0);
    step("s2",  1'b0, 1'b0, 1'b0);
    step("s3",  1'b1, 1'b0, 1'b0);
    step("s4",  1'b0, 1'b1, 1'b1);
    chk("s4_c2_cnt", {30'd0, b2.match_cnt}, 32'd1);
    step("s5",  1'b1, 1'b0, 1'b0);
    step("s6",  1'b0, 1'b1, 1'b0);
    chk("s6_c2_cnt", {30'd0, b2.match_cnt}, 32'd2);
    step("s7",  1'b1, 1'b0, 1'b0);
    step("s8",  1'b0, 1'b1, 1'b1);
    chk("s8_c2_cnt", {30'd0, b2.match_cnt}, 32'd3);
    step("s9",  1'b1, 1'b0, 1'b0);
    step("s10", 1'b0, 1'b1, 1'b0);
    chk("s10_c2_cnt", {30'd0, b2.match_cnt}, 32'd3);
    step("s11", 1'b1, 1'b0, 1'b0);
    step("s12", 1'b0, 1'b1, 1'b1);
    chk("s12_c2_cnt", {30'd0, b2.match_cnt}, 32'd3);
    chk("s_ov_cnt", {24'd0, b0.match_cnt}, 32'd5);
    chk("s_no_cnt", {24'd0, b1.match_cnt}, 32'd3);
    step("s13", 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fsm_1010.md
Name: fsm_1010

Overview:
- Serial sequence detector for the bit pattern 1010 on a single-bit input stream, one bit per clock.
- Moore machine: out is a registered function of state only and pulses high for one cycle when the last four sampled bits equal 1010, oldest bit first.
- Used as a small control/pattern-recognition block.
- Also keeps a saturating count of detections for debug and verification.

Parameters:
- OVERLAP, 1, 1 = overlapping detection (the trailing "10" of a match can start the next match); 0 = non-overlapping (the search restarts after a match).
- CNT_W, 8, width of the match counter.

Ports:
- clk  input  1  rising-edge clock; in is sampled on every rising edge.
- rst  input  1  asynchronous, active-high reset.
- in  input  1  serial data bit, one bit per clk cycle.
- out  output  1  detection flag; high for exactly the one cycle after the edge that samples the final 0 of 1010.
- match_cnt  output  CNT_W  number of detections since reset; saturates at all-ones.

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-high. Ports are clk and rst.
- Reset: while rst=1, regardless of clk, state=S0, out=0 and match_cnt=0. After rst deasserts, the first rising edge samples in normally.
- States: S0 (no progress), S1 (seen 1), S2 (seen 10), S3 (seen 101), S4 (seen 1010, the detect state).
- Transitions on each rising clk edge:
  - S0: in=1 -> S1; in=0 -> S0.
  - S1: in=1 -> S1; in=0 -> S2.
  - S2: in=1 -> S3; in=0 -> S0.
  - S3: in=1 -> S1; in=0 -> S4.
  - S4 with OVERLAP=1: in=1 -> S3; in=0 -> S0.
  - S4 with OVERLAP=0: in=1 -> S1; in=0 -> S0.
- out = 1 exactly when state==S4. Latency is one clock: out rises on the same edge that samples the completing 0 and is valid for that following cycle. out never stays high for two consecutive cycles.
- match_cnt increments by 1 on each edge that enters S4. It holds at 2^CNT_W-1 once reached and never wraps.
- Unused state encodings return to S0 on the next edge, with out=0.
- Reset asserted mid-sequence aborts all partial progress: the bits 1,0,1 followed by reset and then 0 produce no detection.
- in is assumed synchronous to clk. No metastability handling is included.
- Bit order: the first bit sampled is the most significant bit of the pattern.

Test Plan:
- Reset then stream 1,0,1,1,0,1,0 on successive edges (10 ns period) -> out=0 through the 6th edge; out=1 for exactly one cycle after the 7th edge; match_cnt=1. Holding in=0 afterwards keeps out=0.
- OVERLAP=1, stream 1,0,1,0,1,0 -> out pulses after the 4th and after the 6th edge; match_cnt=2.
- OVERLAP=0, stream 1,0,1,0,1,0 -> out pulses only after the 4th edge; match_cnt=1.
- Stream 1,0,1, then assert rst asynchronously between edges, release, then stream 0 -> out stays 0 throughout; match_cnt=0. Reset clears out immediately, without waiting for clk, even while in S4.
- Stream 1,1,1,0,0,1,0,1,0 -> exactly one pulse, after the 9th edge. The earlier 1,1,1,0,0 produces no pulse.
- CNT_W=2 with 5 overlapping matches -> match_cnt reads 1, 2, 3, 3, 3, saturating at 3.
